// File: rtl/ni_flit_injector.sv
// Network-interface packet injector: buffers payload words, runs a 4-phase req/ack handshake,
// then streams a gap-free header/payload/tail flit train into the router input buffer.
module ni_flit_injector #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DEPTH   = 8,
   parameter logic [3:0]  NODE_ID = 4'b0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DATA_W-1:0]      payload_in,
   input  logic                   send,
   input  logic [3:0]             dest_addr,
   input  logic                   ack_out,
   output logic                   req_out,
   output logic [DATA_W+1:0]      flit_out,
   output logic                   flit_valid,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef enum logic [2:0] {
      StIdle, StReq, StRelease, StHdr, StPay, StTail, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        dest_q, dest_d;
   logic [CW-1:0]     pay_left_q, pay_left_d;
   logic [DATA_W-1:0] csum_q, csum_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] hdr_data;
   logic              do_push, do_pop;

   assign head     = mem_q[rd_ptr_q];
   assign hdr_data = DATA_W'({dest_q, NODE_ID});

   always_comb begin
      state_d    = state_q;
      dest_d     = dest_q;
      pay_left_d = pay_left_q;
      csum_d     = csum_q;
      do_push    = 1'b0;
      do_pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (send) begin
               dest_d     = dest_addr;
               pay_left_d = count_q;
               csum_d     = '0;
               state_d    = StReq;
            end else if (push && !full) begin
               do_push = 1'b1;
            end
         end
         StReq:     if (ack_out) state_d = StRelease;
         StRelease: state_d = StHdr;
         StHdr:     state_d = (pay_left_q != '0) ? StPay : StTail;
         StPay: begin
            do_pop     = 1'b1;
            csum_d     = csum_q ^ head;
            pay_left_d = pay_left_q - CW'(1);
            if (pay_left_q == CW'(1)) state_d = StTail;
         end
         StTail:    state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Circular pointers wrap explicitly so non-power-of-two depths work too.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         count_d  = count_q + CW'(1);
      end else if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         count_d  = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         dest_q     <= '0;
         pay_left_q <= '0;
         csum_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         dest_q     <= dest_d;
         pay_left_q <= pay_left_d;
         csum_q     <= csum_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= payload_in;
   end

   always_comb begin
      flit_out   = '0;
      flit_valid = 1'b0;
      unique case (state_q)
         StHdr: begin
            flit_valid = 1'b1;
            flit_out   = {2'b01, hdr_data};
         end
         StPay: begin
            flit_valid = 1'b1;
            flit_out   = {2'b00, head};
         end
         StTail: begin
            flit_valid = 1'b1;
            flit_out   = {2'b10, csum_q};
         end
         default: ;
      endcase
   end

   assign req_out = (state_q == StReq);
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;

endmodule

// File: tb/tb_ni_flit_injector.sv
// Scoreboard bench for ni_flit_injector: expected flits are queued at stimulus time and a
// negedge monitor pops and compares every delivered flit.
module tb_ni_flit_injector;

   logic       clk = 1'b0;
   logic       rst;
   logic       push;
   logic [7:0] payload_in;
   logic       send;
   logic [3:0] dest_addr;
   logic       ack_out = 1'b0;
   logic       req_out;
   logic [9:0] flit_out;
   logic       flit_valid;
   logic       full;
   logic [3:0] count;
   logic       busy;
   logic       done;

   ni_flit_injector #(
      .DATA_W (8),
      .DEPTH  (8),
      .NODE_ID(4'b0110)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .payload_in(payload_in),
      .send      (send),
      .dest_addr (dest_addr),
      .ack_out   (ack_out),
      .req_out   (req_out),
      .flit_out  (flit_out),
      .flit_valid(flit_valid),
      .full      (full),
      .count     (count),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   logic [9:0] exp_q[$];
   int run_cur = 0;
   int run_len = 0;
   int first_cyc = 0;
   int done_pulses = 0;
   bit ack_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream buffer: ack follows req with one cycle of delay.
   always @(posedge clk) ack_out <= ack_en & req_out;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (flit_valid) begin
         run_cur++;
         if (run_cur == 1) first_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_flit: got 0x%0h expected no flit", flit_out);
         end else begin
            check("flit", {22'd0, flit_out}, {22'd0, exp_q.pop_front()});
         end
      end else begin
         if (run_cur != 0) begin
            run_len = run_cur;
            check("flit_zero_when_invalid", {22'd0, flit_out}, 32'd0);
         end
         run_cur = 0;
      end
      if (done) done_pulses++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] w);
      push = 1'b1;
      payload_in = w;
      tick();
      push = 1'b0;
   endtask

   // Waits for done; optionally pokes push/send once in REQ and once in PAY.
   task automatic wait_done(input int nflits, input bit poke);
      bit ok = 1'b0;
      bit poked_req = 1'b0;
      bit poked_pay = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         push = 1'b0;
         send = 1'b0;
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (poke && !poked_req && req_out) begin
            poked_req = 1'b1;
            push = 1'b1; payload_in = 8'hEE; send = 1'b1; dest_addr = 4'h0;
         end else if (poke && !poked_pay && flit_valid && flit_out[9:8] == 2'b00) begin
            poked_pay = 1'b1;
            push = 1'b1; payload_in = 8'hEE; send = 1'b1; dest_addr = 4'h0;
         end
      end
      check("done_seen", {31'd0, ok}, 32'd1);
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("done_pulses", done_pulses, 1);
      check("busy_after", {31'd0, busy}, 32'd0);
      check("count_after", {28'd0, count}, 32'd0);
      check("train_len", run_len, nflits);
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic run_packet(input logic [3:0] d, input int nflits, input bit poke);
      int e0;
      done_pulses = 0;
      dest_addr = d;
      send = 1'b1;
      e0 = cyc + 1;
      tick();
      send = 1'b0;
      wait_done(nflits, poke);
      check("hdr_latency", first_cyc, e0 + 3);
   endtask

   initial begin
      int npay;
      bit req_low;
      bit any_flit;
      rst = 1'b1; push = 1'b0; payload_in = '0; send = 1'b0; dest_addr = '0;
      tick();
      tick();
      check("rst_req", {31'd0, req_out}, 32'd0);
      check("rst_flit", {22'd0, flit_out}, 32'd0);
      check("rst_valid", {31'd0, flit_valid}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_count", {28'd0, count}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      tick();

      // Stalled handshake on an empty FIFO, with ignored push/send during REQ.
      ack_en = 1'b0;
      done_pulses = 0;
      dest_addr = 4'b0011;
      send = 1'b1;
      tick();
      send = 1'b0;
      check("stall_req_rise", {31'd0, req_out}, 32'd1);
      check("stall_busy", {31'd0, busy}, 32'd1);
      req_low = 1'b0;
      any_flit = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin push = 1'b1; payload_in = 8'h77; end
         if (i == 3) begin send = 1'b1; dest_addr = 4'hC; end
         tick();
         push = 1'b0;
         send = 1'b0;
         if (!req_out) req_low = 1'b1;
         if (flit_valid) any_flit = 1'b1;
      end
      check("stall_req_held", {31'd0, req_low}, 32'd0);
      check("stall_no_flit", {31'd0, any_flit}, 32'd0);
      check("stall_count", {28'd0, count}, 32'd0);
      exp_q.push_back(10'h136);
      exp_q.push_back(10'h200);
      ack_en = 1'b1;
      wait_done(2, 1'b0);

      // Three-payload packet.
      push_word(8'hA1);
      push_word(8'h5C);
      push_word(8'h0F);
      check("count3", {28'd0, count}, 32'd3);
      exp_q.push_back(10'h196);
      exp_q.push_back(10'h0A1);
      exp_q.push_back(10'h05C);
      exp_q.push_back(10'h00F);
      exp_q.push_back(10'h2F2);
      run_packet(4'b1001, 5, 1'b0);

      // Zero-payload packet.
      exp_q.push_back(10'h136);
      exp_q.push_back(10'h200);
      run_packet(4'b0011, 2, 1'b0);

      // Full FIFO, overflow push dropped, pokes during REQ and PAY ignored.
      for (int i = 1; i <= 8; i++) push_word(8'(i));
      check("full_flag", {31'd0, full}, 32'd1);
      check("full_count", {28'd0, count}, 32'd8);
      push_word(8'h09);
      check("overflow_count", {28'd0, count}, 32'd8);
      exp_q.push_back(10'h1F6);
      for (int i = 1; i <= 8; i++) exp_q.push_back(10'(i));
      exp_q.push_back(10'h208);
      run_packet(4'b1111, 10, 1'b1);

      // Reset during the second payload cycle of a 4-payload packet.
      push_word(8'h11);
      push_word(8'h22);
      push_word(8'h33);
      push_word(8'h44);
      exp_q.push_back(10'h156);
      exp_q.push_back(10'h011);
      exp_q.push_back(10'h022);
      exp_q.push_back(10'h033);
      exp_q.push_back(10'h044);
      exp_q.push_back(10'h244);
      dest_addr = 4'b0101;
      send = 1'b1;
      tick();
      send = 1'b0;
      npay = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (flit_valid && flit_out[9:8] == 2'b00) npay++;
         if (npay == 2) break;
      end
      check("reached_pay2", npay, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      check("midrst_valid", {31'd0, flit_valid}, 32'd0);
      check("midrst_req", {31'd0, req_out}, 32'd0);
      check("midrst_count", {28'd0, count}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      tick();

      // One-payload packet after the reset.
      push_word(8'h5A);
      exp_q.push_back(10'h1A6);
      exp_q.push_back(10'h05A);
      exp_q.push_back(10'h25A);
      run_packet(4'b1010, 3, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ni_flit_injector.md
# ni_flit_injector

Network-interface packet injector: the transmitting end of the req/ack link that feeds a router input buffer unit. A local core pushes payload words into an internal FIFO, then issues `send`. The block then:
- performs the 4-phase request/acknowledge handshake,
- streams a gap-free flit train (header, payloads, tail) that the buffer unit writes one flit per cycle.

It sits between a mesh node's core and the local input port of its router.

## Interface
Parameters:
- `DATA_W`, 8, flit data width; header data is `{dest[3:0], src[3:0]}` (4x4 mesh, x/y 2 bits each).
- `DEPTH`, 8, payload FIFO depth (max payload flits per packet).
- `NODE_ID`, 4'b0000, this node's address, placed in header `src`.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `push` in 1: write `payload_in` into the FIFO.
- `payload_in` in DATA_W: payload word.
- `send` in 1: launch a packet containing all words currently in the FIFO.
- `dest_addr` in 4: destination node, sampled when `send` is accepted.
- `ack_out` in 1: acknowledge from the downstream buffer unit.
- `req_out` out 1: request to the downstream buffer unit.
- `flit_out` out DATA_W+2: `{flit_type[1:0], data}`. Types: HEADER=2'b01, PAYLOAD=2'b00, TAIL=2'b10.
- `flit_valid` out 1: high in each cycle a flit is being delivered.
- `full` out 1: FIFO holds DEPTH words.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse after the tail flit.

## Operation
- States: IDLE, REQ, RELEASE, HDR, PAY, TAIL, DONE.
- **IDLE**
  - `push` is accepted only when `send`=0 and `full`=0; otherwise the word is dropped.
  - `send`=1 latches `dest_addr`, latches `count` into `pay_left`, clears the checksum, and moves to REQ.
- **REQ**: `req_out`=1. Stay in REQ until `ack_out` is sampled 1, then go to RELEASE.
- **RELEASE**: `req_out`=0 for exactly one cycle, no flit driven (`flit_valid`=0). Go to HDR unconditionally.
  - This satisfies the receiver: it sees req low at the end of this cycle and begins writing the next cycle.
- **HDR**: drive `{2'b01, dest, NODE_ID}`. Go to PAY if `pay_left`≠0, else TAIL.
- **PAY**
  - Drive `{2'b00, fifo_head}`, pop the FIFO, XOR the word into the checksum, decrement `pay_left`.
  - Go to TAIL when `pay_left` reaches 1 in this cycle, i.e. after the last payload.
- **TAIL**: drive `{2'b10, checksum}`. The checksum is the XOR of all payload words, 0 when there are none. Go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `push` and `send` are ignored in every state except IDLE.
- `flit_out` is 0 whenever `flit_valid`=0.
- There is no downstream backpressure after the handshake: the flit train is never stalled.
- FIFO: circular, pointers wrap modulo DEPTH. `count` is incremented by push and decremented by pop (never both in one cycle).

## Timing
- All outputs are registered from state/datapath. Reset values: `req_out`=0, `flit_out`=0, `flit_valid`=0, `full`=0, `count`=0, `busy`=0, `done`=0. FIFO pointers are 0.
- Reset in any state, including mid-train:
  - Next cycle the block is in IDLE with all outputs at reset values.
  - FIFO contents are discarded.
  - `req_out` drops immediately after the reset edge.
- Minimum latency, with `send` sampled at edge E0:
  - REQ covers E0–E1 (at least one cycle).
  - With `ack_out` rising at E1 and sampled at E2: RELEASE E2–E3, HDR E3–E4.
  - N payloads follow, then the tail, then DONE.
  - A packet with N payloads occupies N+2 consecutive `flit_valid` cycles.
- `ack_out` held low indefinitely: the block stays in REQ with `req_out`=1 and `flit_valid`=0.
- `send` with `count`=0 produces a 2-flit packet: header, then tail with data 0.

## Test plan
- **Reset:** assert `rst` for 2 cycles, then check every output is 0 and `busy`=0. Then `send` with `ack_out` tied 0 → `req_out`=1 from the next cycle, held, with no flits.
- **3-payload packet:**
  - Stimulus: push 8'hA1, 8'h5C, 8'h0F; `send` with dest 4'b1001, NODE_ID 4'b0110; downstream model raises `ack_out` one cycle after `req_out` and drops it one cycle after `req_out` falls.
  - Required flits on consecutive cycles: 10'h196, 10'h0A1, 10'h05C, 10'h00F, 10'h2F2. Then `done` pulses once and `count`=0.
- **Zero-payload packet:** `send` on an empty FIFO with dest 4'b0011 → header {01, 0011, NODE_ID}, then tail 10'h200. 2 valid cycles.
- **Full FIFO:**
  - Push 8 words 8'h01…8'h08 → `full`=1, `count`=8. A 9th push is ignored.
  - `send` → 10 flits with the payloads in order; tail data = 8'h08.
- **Stalled handshake and ignored inputs:**
  - Hold `ack_out`=0 for 6 cycles → `req_out` stays 1 and no flits.
  - `push`/`send` pulses during REQ/PAY leave `count` and the packet unchanged.
- **Reset mid-train:** assert `rst` during the second PAY cycle of a 4-payload packet → next cycle `flit_valid`=0, `req_out`=0, `count`=0, state IDLE. A new 1-payload packet afterwards is correct.
